kvaz_write_queue: RTL

KVAZ_WRITE_QUEUE -- requirements
Module: kvaz_write_queue

---
 rtl/kvaz_write_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/kvaz_write_queue.sv
// Posted-write queue between the bus side and sdram_arbitre, one read at a time.
// Optional read forwarding from queued writes: define KVAZ_QUEUE_FWD_EN.
module kvaz_write_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vu_write,
   input  logic        vu_read,
   input  logic [17:0] vu_adrs,
   input  logic [7:0]  vu_data_i,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [17:0] arb_adrs,
   output logic [7:0]  arb_data,
   output logic        arb_write,
   output logic        arb_read,
   input  logic        arb_ack,
   input  logic [7:0]  arb_rdata,
   output logic        full,
   output logic        empty,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_DONE} state_t;

   state_t         state;
   state_t         state_nx;
   logic [17:0]    q_adrs [DEPTH];
   logic [7:0]     q_data [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           rd_pend;
   logic [17:0]    rd_adrs;
   logic           fwd_q;
   logic           push;
   logic           pop;
   logic           rd_busy;
   logic           rd_take;
   logic           rd_hit;
   logic [7:0]     hit_data;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop     = (state == WR_ISSUE) && arb_ack;
   assign push    = vu_write && (!full || pop);
   assign rd_busy = rd_pend || fwd_q
                 || (state == RD_ISSUE) || (state == RD_DONE);
   assign rd_take = vu_read && !rd_busy;

`ifdef KVAZ_QUEUE_FWD_EN
   // Oldest to newest so the last match wins; a same-cycle write is newest.
   always_comb begin
      rd_hit   = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count
             && q_adrs[rd_ptr + AW'(i)] == vu_adrs) begin
            rd_hit   = 1'b1;
            hit_data = q_data[rd_ptr + AW'(i)];
         end
      end
      if (push) begin
         rd_hit   = 1'b1;
         hit_data = vu_data_i;
      end
   end
`else
   assign rd_hit   = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         q_adrs[wr_ptr] <= vu_adrs;
         q_data[wr_ptr] <= vu_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (vu_write && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rd_pend <= 1'b0;
         rd_adrs <= '0;
         fwd_q   <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         state <= state_nx;
         fwd_q <= rd_take && rd_hit;
         if (rd_take && !rd_hit) begin
            rd_pend <= 1'b1;
            rd_adrs <= vu_adrs;
         end else if (state_nx == RD_ISSUE) begin
            rd_pend <= 1'b0;
         end
         if (rd_take && rd_hit)
            rd_data <= hit_data;
         else if (state == RD_ISSUE && arb_ack)
            rd_data <= arb_rdata;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
`ifdef KVAZ_QUEUE_FWD_EN
            if (rd_pend)     state_nx = RD_ISSUE;
            else if (!empty) state_nx = WR_ISSUE;
`else
            if (!empty)       state_nx = WR_ISSUE;
            else if (rd_pend) state_nx = RD_ISSUE;
`endif
         end
         WR_ISSUE: if (arb_ack) state_nx = IDLE;
         RD_ISSUE: if (arb_ack) state_nx = RD_DONE;
         RD_DONE:  state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign arb_write = (state == WR_ISSUE);
   assign arb_read  = (state == RD_ISSUE);
   assign arb_adrs  = arb_read ? rd_adrs : q_adrs[rd_ptr];
   assign arb_data  = q_data[rd_ptr];
   assign rd_valid  = (state == RD_DONE) || fwd_q;

endmodule
